// File: rtl/memory_hs.sv
// memory_hs: single-port synchronous RAM with valid/ready request handshake, registered
// read data and a zero-fill clear sweep. Optional per-word even parity: define MEM_PARITY_EN.
module memory_hs #(
  parameter int BITS       = 16,
  parameter int ADDR_BITS  = 8,
  parameter int DEPTH      = 256,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req,
  input  logic                 i_rw,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [BITS-1:0]      i_data,
  input  logic                 i_clear,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [BITS-1:0]      o_data,
  output logic                 o_busy,
  output logic                 o_perr
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;
  localparam int         STAGES  = 1;
  localparam int         AW1     = ADDR_BITS + 1;
`ifdef MEM_PARITY_EN
  localparam int         WW      = BITS + 1;
`else
  localparam int         WW      = BITS;
`endif
  localparam logic [AW1-1:0]       DEPTH_W = AW1'(DEPTH);
  localparam logic [ADDR_BITS-1:0] LAST    = ADDR_BITS'(DEPTH - 1);

  typedef struct packed {
    logic                 rw;
    logic [ADDR_BITS-1:0] addr;
    logic [BITS-1:0]      data;
  } req_t;

  logic [WW-1:0]        mem [DEPTH];
  logic [0:0]           state;
  logic [ADDR_BITS-1:0] cnt;
  logic [STAGES:0]      vld_pipe;
  req_t                 req;
  logic                 acc, in_range, wr_acc, rd_acc;
  logic [WW-1:0]        wr_word, rd_word;

  assign req      = '{rw: i_rw, addr: i_addr, data: i_data};
  assign o_ready  = (state == S_IDLE) && !i_rst;
  assign o_busy   = (state == S_CLEAR);
  assign acc      = i_req && o_ready;
  assign in_range = {1'b0, req.addr} < DEPTH_W;
  assign wr_acc   = acc && req.rw && in_range;
  assign rd_acc   = acc && !req.rw;
  assign rd_word  = mem[req.addr];

`ifdef MEM_PARITY_EN
  assign wr_word = {^req.data, req.data};
`else
  assign wr_word = req.data;
`endif

  // Array is never reset; the sweep owns the port for its whole duration.
  always_ff @(posedge i_clk) begin
    if (state == S_CLEAR)
      mem[cnt] <= '0;
    else if (wr_acc)
      mem[req.addr] <= wr_word;
  end

  assign vld_pipe[0] = rd_acc;
  assign o_valid     = vld_pipe[STAGES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state                <= INIT_CLEAR ? S_CLEAR : S_IDLE;
      cnt                  <= '0;
      o_data               <= '0;
      vld_pipe[STAGES:1]   <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      // Out-of-range reads still complete, returning zero.
      if (rd_acc)
        o_data <= in_range ? rd_word[BITS-1:0] : '0;
      case (state)
        S_IDLE: begin
          if (i_clear) begin
            state <= S_CLEAR;
            cnt   <= '0;
          end
        end
        S_CLEAR: begin
          if (cnt == LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_PARITY_EN
  // Stored word including its parity bit must XOR to zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      o_perr <= 1'b0;
    else
      o_perr <= rd_acc && in_range && (^rd_word);
  end
`else
  assign o_perr = 1'b0;
`endif

endmodule

// File: tb/tb_memory_hs.sv
// Directed bench for memory_hs: vector table for single transactions plus hand sequences
// for sweep timing, back-to-back reads, out-of-range access and reset during a sweep.
module tb_memory_hs;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req = 1'b0, i_rw = 1'b0, i_clear = 1'b0;
  logic [7:0]  i_addr = '0;
  logic [15:0] i_data = '0;
  logic        o_ready, o_valid, o_busy, o_perr;
  logic [15:0] o_data;

  logic        req2 = 1'b0, rw2 = 1'b0;
  logic [7:0]  addr2 = '0;
  logic [15:0] data2 = '0;
  logic        ready2, valid2, busy2, perr2;
  logic [15:0] odata2;

  int pass_cnt = 0, total_cnt = 0;

  always #5 i_clk = ~i_clk;

  memory_hs #(.BITS(16), .ADDR_BITS(8), .DEPTH(256), .INIT_CLEAR(1'b1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_rw(i_rw), .i_addr(i_addr),
    .i_data(i_data), .i_clear(i_clear), .o_ready(o_ready), .o_valid(o_valid),
    .o_data(o_data), .o_busy(o_busy), .o_perr(o_perr));

  memory_hs #(.BITS(16), .ADDR_BITS(8), .DEPTH(200), .INIT_CLEAR(1'b1)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(req2), .i_rw(rw2), .i_addr(addr2),
    .i_data(data2), .i_clear(1'b0), .o_ready(ready2), .o_valid(valid2),
    .o_data(odata2), .o_busy(busy2), .o_perr(perr2));

  typedef struct {
    logic        rw;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;   // read result, or held o_data after a write
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      pass_cnt++;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic rw, input logic [7:0] a, input logic [15:0] d);
    int n = 0;
    i_req = 1'b1; i_rw = rw; i_addr = a; i_data = d;
    while (!o_ready && n < 1000) begin
      @(negedge i_clk);
      n++;
    end
    chk("issue_ready", {31'd0, o_ready}, 32'd1);
    @(negedge i_clk);
    i_req = 1'b0;
  endtask

  task automatic count_busy(input string nm);
    int n = 0;
    while (o_busy && n < 1000) begin
      chk("sweep_not_ready", {31'd0, o_ready}, 32'd0);
      @(negedge i_clk);
      n++;
    end
    chk(nm, n, 32'd256);
    chk({nm, "_ready"}, {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    int n, bad;
    tbl[0]  = '{1'b0, 8'd0,   16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, 8'd17,  16'h0000, 16'h0000};
    tbl[2]  = '{1'b0, 8'd255, 16'h0000, 16'h0000};
    tbl[3]  = '{1'b1, 8'd0,   16'h0081, 16'h0000};
    tbl[4]  = '{1'b0, 8'd0,   16'h0000, 16'h0081};
    tbl[5]  = '{1'b1, 8'd1,   16'h0100, 16'h0081};
    tbl[6]  = '{1'b1, 8'd2,   16'hBEEF, 16'h0081};
    tbl[7]  = '{1'b1, 8'd3,   16'hFFFF, 16'h0081};
    tbl[8]  = '{1'b1, 8'd5,   16'h00AA, 16'h0081};
    tbl[9]  = '{1'b0, 8'd2,   16'h0000, 16'hBEEF};
    tbl[10] = '{1'b1, 8'd255, 16'h1357, 16'hBEEF};
    tbl[11] = '{1'b0, 8'd255, 16'h0000, 16'h1357};
    tbl[12] = '{1'b0, 8'd17,  16'h0000, 16'h0000};
    tbl[13] = '{1'b1, 8'd9,   16'h0003, 16'h0000};
    tbl[14] = '{1'b1, 8'd10,  16'h0001, 16'h0000};

    // Reset state
    repeat (3) @(negedge i_clk);
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    chk("rst_busy",  {31'd0, o_busy},  32'd1);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_data",  {16'd0, o_data},  32'd0);
    chk("rst_perr",  {31'd0, o_perr},  32'd0);
    i_rst = 1'b0;
    count_busy("init_sweep_len");

    // Single-transaction vectors
    foreach (tbl[i]) begin
      issue(tbl[i].rw, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("vec%0d_valid", i), {31'd0, o_valid}, {31'd0, ~tbl[i].rw});
      chk($sformatf("vec%0d_data", i), {16'd0, o_data}, {16'd0, tbl[i].exp});
      if (!tbl[i].rw) begin
        chk($sformatf("vec%0d_perr", i), {31'd0, o_perr}, 32'd0);
        @(negedge i_clk);
        chk($sformatf("vec%0d_valid_drop", i), {31'd0, o_valid}, 32'd0);
        chk($sformatf("vec%0d_hold", i), {16'd0, o_data}, {16'd0, tbl[i].exp});
      end
    end

    // Back-to-back reads of 1, 2, 3
    i_req = 1'b1; i_rw = 1'b0; i_addr = 8'd1;
    @(negedge i_clk);
    chk("b2b0_valid", {31'd0, o_valid}, 32'd1);
    chk("b2b0_data", {16'd0, o_data}, 32'h0100);
    i_addr = 8'd2;
    @(negedge i_clk);
    chk("b2b1_valid", {31'd0, o_valid}, 32'd1);
    chk("b2b1_data", {16'd0, o_data}, 32'hBEEF);
    i_addr = 8'd3;
    @(negedge i_clk);
    chk("b2b2_valid", {31'd0, o_valid}, 32'd1);
    chk("b2b2_data", {16'd0, o_data}, 32'hFFFF);
    i_req = 1'b0;
    @(negedge i_clk);
    chk("b2b_end_valid", {31'd0, o_valid}, 32'd0);

    // Parity: addr 9 holds 0x0003, addr 10 holds 0x0001
`ifdef MEM_PARITY_EN
    dut.mem[9][16] = ~dut.mem[9][16];
    issue(1'b0, 8'd9, 16'h0000);
    chk("par9_valid", {31'd0, o_valid}, 32'd1);
    chk("par9_perr", {31'd0, o_perr}, 32'd1);
    @(negedge i_clk);
    chk("par9_perr_drop", {31'd0, o_perr}, 32'd0);
    issue(1'b0, 8'd10, 16'h0000);
    chk("par10_perr", {31'd0, o_perr}, 32'd0);
`else
    issue(1'b0, 8'd9, 16'h0000);
    chk("rd9_data", {16'd0, o_data}, 32'h0003);
    chk("rd9_perr", {31'd0, o_perr}, 32'd0);
    issue(1'b0, 8'd10, 16'h0000);
    chk("rd10_data", {16'd0, o_data}, 32'h0001);
`endif
    @(negedge i_clk);

    // Out of range on the DEPTH=200 instance
    chk("oor_ready", {31'd0, ready2}, 32'd1);
    req2 = 1'b1; rw2 = 1'b1; addr2 = 8'd210; data2 = 16'h1234;
    @(negedge i_clk);
    chk("oor_wr_valid", {31'd0, valid2}, 32'd0);
    rw2 = 1'b0;
    @(negedge i_clk);
    chk("oor_rd_valid", {31'd0, valid2}, 32'd1);
    chk("oor_rd_data", {16'd0, odata2}, 32'h0000);
    chk("oor_rd_perr", {31'd0, perr2}, 32'd0);
    rw2 = 1'b1; addr2 = 8'd199; data2 = 16'h5A5A;
    @(negedge i_clk);
    chk("last_wr_valid", {31'd0, valid2}, 32'd0);
    chk("last_wr_hold", {16'd0, odata2}, 32'h0000);
    rw2 = 1'b0;
    @(negedge i_clk);
    chk("last_rd_data", {16'd0, odata2}, 32'h5A5A);
    addr2 = 8'd10;
    @(negedge i_clk);
    chk("oor_unchanged10", {16'd0, odata2}, 32'h0000);
    addr2 = 8'd0;
    @(negedge i_clk);
    chk("oor_unchanged0", {16'd0, odata2}, 32'h0000);
    req2 = 1'b0;
    @(negedge i_clk);
    chk("oor_valid_drop", {31'd0, valid2}, 32'd0);

    // Read of addr 5 with i_clear on the same edge, request held through the sweep
    i_req = 1'b1; i_rw = 1'b0; i_addr = 8'd5; i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
    chk("clr_rd_valid", {31'd0, o_valid}, 32'd1);
    chk("clr_rd_data", {16'd0, o_data}, 32'h00AA);
    chk("clr_busy", {31'd0, o_busy}, 32'd1);
    n = 0; bad = 0;
    while (!o_ready && n < 1000) begin
      n++;
      i_clear = (n == 50);
      @(negedge i_clk);
      if (o_valid) bad++;
    end
    i_clear = 1'b0;
    chk("clr_sweep_len", n, 32'd256);
    chk("clr_held_ignored", bad, 32'd0);
    @(negedge i_clk);
    i_req = 1'b0;
    chk("clr_reread_valid", {31'd0, o_valid}, 32'd1);
    chk("clr_reread_data", {16'd0, o_data}, 32'h0000);

    // Reset 100 cycles into a sweep restarts it
    issue(1'b1, 8'd0, 16'h0081);
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
    repeat (99) @(negedge i_clk);
    chk("mid_sweep_busy", {31'd0, o_busy}, 32'd1);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, o_ready}, 32'd0);
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd1);
    @(negedge i_clk);
    i_rst = 1'b0;
    count_busy("restart_sweep_len");
    issue(1'b0, 8'd0, 16'h0000);
    chk("restart_rd0", {16'd0, o_data}, 32'h0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
